// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side stream master.
package fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the reader.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic                  o_fifo_read;
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;

  modport master (
    output o_fifo_read, o_valid, o_data, o_last,
    input  i_fifo_empty, i_fifo_data, i_ready
  );

  modport slave (
    input  o_fifo_read, o_valid, o_data, o_last,
    output i_fifo_empty, i_fifo_data, i_ready
  );
endinterface

// File: rtl/fifo_rd_buf.sv
// Small circular output buffer: push at tail, pop from head, exposes occupancy.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int BUF_DEPTH  = 2,
  localparam int PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [OCC_W-1:0]      occ_o
);
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  // Wraps modulo BUF_DEPTH, so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from the project FIFO, absorbs its one-cycle read latency, and
// presents them as a registered valid/ready stream framed into bursts by o_last.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_enable,
  fifo_stream_reader_if.master bus,
  output logic                 o_busy
);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int LVL_W = OCC_W + 1;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  rd_state_t             state_q, state_d;
  logic                  inflight_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OCC_W-1:0]      occ;
  logic [DATA_WIDTH-1:0] head;
  logic [LVL_W-1:0]      level;
  logic                  has_data, pop, busy, rd_room;

  assign has_data = i_rst_n & (occ != '0);
  assign pop      = has_data & bus.i_ready;
  assign busy     = inflight_q | (occ != '0);
  // Count in-flight reads against capacity so a read never lands in a full buffer.
  assign level    = LVL_W'(occ) + LVL_W'(inflight_q) - LVL_W'(pop);
  assign rd_room  = (level < LVL_W'(BUF_DEPTH));

  fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .push_i (inflight_q),
    .pop_i  (pop),
    .data_i (bus.i_fifo_data),
    .head_o (head),
    .occ_o  (occ)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = (cnt_q == CNT_W'(BURST_LEN - 1)) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= bus.o_fifo_read;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (!i_enable) state_d = busy ? DRAIN : IDLE;
      DRAIN:   if (i_enable) state_d = RUN;
               else if (!busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_fifo_read = i_rst_n & i_enable & ~bus.i_fifo_empty & rd_room;
    bus.o_valid     = has_data;
    bus.o_data      = has_data ? head : '0;
    bus.o_last      = has_data & (cnt_q == CNT_W'(BURST_LEN - 1));
    o_busy          = i_rst_n & busy;
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model, expected-beat queue, decoupled monitor.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  localparam int DW = 32;
  localparam int BD = 2;
  localparam int BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, enable, busy;
  logic force_empty, flush;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (BD),
    .BURST_LEN  (BL)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .bus      (bus),
    .o_busy   (busy)
  );

  // Upstream FIFO model with registered read data.
  logic [DW-1:0] fmem [64];
  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;
  int unsigned nreads = 0;

  assign bus.i_fifo_empty = force_empty | (wr_idx == rd_idx);

  always @(posedge clk) begin
    if (flush) rd_idx <= wr_idx;
    else if (bus.o_fifo_read && !bus.i_fifo_empty) begin
      bus.i_fifo_data <= fmem[rd_idx[5:0]];
      rd_idx          <= rd_idx + 1;
    end
    if (bus.o_fifo_read) nreads <= nreads + 1;
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0h, expected no beat", bus.o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("beat_data", 64'(bus.o_data), 64'(e.d));
        check("beat_last", 64'(bus.o_last), 64'(e.l));
      end
    end
  end

  always @(negedge clk) begin
    assert (int'(dut.occ) <= BD) else $error("buffer occupancy %0d above depth", dut.occ);
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [DW-1:0] d);
    fmem[wr_idx[5:0]] = d;
    wr_idx = wr_idx + 1;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin
      cyc();
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned base;
    int k;
    logic seen_rd, seen_v;

    rst_n       = 1'b0;
    enable      = 1'b0;
    bus.i_ready = 1'b0;
    force_empty = 1'b0;
    flush       = 1'b0;

    // 1) reset with random inputs
    repeat (3) begin
      @(posedge clk);
      #1;
      enable      = 1'($urandom_range(0, 1));
      bus.i_ready = 1'($urandom_range(0, 1));
      force_empty = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("rst_fifo_read", 64'(bus.o_fifo_read), 64'd0);
    check("rst_valid",     64'(bus.o_valid),     64'd0);
    check("rst_data",      64'(bus.o_data),      64'd0);
    check("rst_last",      64'(bus.o_last),      64'd0);
    check("rst_busy",      64'(busy),            64'd0);
    check("rst_state",     64'(dut.state_q),     64'(IDLE));
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    enable      = 1'b0;
    bus.i_ready = 1'b0;
    force_empty = 1'b0;
    cyc(2);

    // 2) four preloaded words, full throughput, cycle-exact timing
    expect_beat(32'hA0, 1'b0);
    expect_beat(32'hA1, 1'b0);
    expect_beat(32'hA2, 1'b0);
    expect_beat(32'hA3, 1'b1);
    load(32'hA0); load(32'hA1); load(32'hA2); load(32'hA3);
    bus.i_ready = 1'b1;
    enable      = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("t2_fifo_read", 64'(bus.o_fifo_read), 64'(c <= 3));
      check("t2_valid",     64'(bus.o_valid),     64'(c >= 2 && c <= 5));
      check("t2_busy",      64'(busy),            64'(c >= 1 && c <= 5));
      @(posedge clk);
      #1;
    end
    wait_drain("t2_drain", 4);

    // 3) backpressure: only two reads fit, head held, then released
    bus.i_ready = 1'b0;
    expect_beat(32'hA0, 1'b0);
    expect_beat(32'hA1, 1'b0);
    expect_beat(32'hA2, 1'b0);
    expect_beat(32'hA3, 1'b1);
    expect_beat(32'hA4, 1'b0);
    base = nreads;
    load(32'hA0); load(32'hA1); load(32'hA2); load(32'hA3); load(32'hA4);
    cyc(6);
    check("t3_reads_held", 64'(nreads - base), 64'd2);
    check("t3_fifo_read",  64'(bus.o_fifo_read), 64'd0);
    check("t3_valid",      64'(bus.o_valid),     64'd1);
    check("t3_data_held",  64'(bus.o_data),      64'hA0);
    bus.i_ready = 1'b1;
    wait_drain("t3_drain", 20);
    cyc(2);
    check("t3_reads_total", 64'(nreads - base), 64'd5);

    // 4) empty flag forced while data waits behind it
    force_empty = 1'b1;
    load(32'hB0); load(32'hB1);
    seen_rd = 1'b0;
    seen_v  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen_rd = seen_rd | bus.o_fifo_read;
      seen_v  = seen_v | bus.o_valid;
    end
    check("t4_no_read",  64'(seen_rd),        64'd0);
    check("t4_no_valid", 64'(seen_v),         64'd0);
    check("t4_state",    64'(dut.state_q),    64'(RUN));
    @(posedge clk);
    #1;
    expect_beat(32'hB0, 1'b0);
    expect_beat(32'hB1, 1'b0);
    force_empty = 1'b0;
    wait_drain("t4_drain", 20);
    cyc(2);

    // 5) enable dropped after the second read
    expect_beat(32'hC0, 1'b1);
    expect_beat(32'hC1, 1'b0);
    base = nreads;
    load(32'hC0); load(32'hC1); load(32'hC2); load(32'hC3);
    cyc(2);
    enable = 1'b0;
    cyc();
    check("t5_state_drain", 64'(dut.state_q), 64'(DRAIN));
    k = 0;
    while (dut.state_q != IDLE && k < 10) begin
      cyc();
      k++;
    end
    check("t5_state_idle", 64'(dut.state_q), 64'(IDLE));
    cyc(5);
    check("t5_reads", 64'(nreads - base), 64'd2);
    check("t5_busy",  64'(busy),          64'd0);
    wait_drain("t5_drain", 4);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // 6) reset mid-burst clears the beat counter and discards buffered words
    enable = 1'b1;
    expect_beat(32'hD0, 1'b0);
    expect_beat(32'hD1, 1'b0);
    load(32'hD0); load(32'hD1);
    wait_drain("t6_pre_drain", 20);
    bus.i_ready = 1'b0;
    load(32'hE0); load(32'hE1);
    cyc(4);
    check("t6_buffered", 64'(bus.o_valid), 64'd1);
    rst_n = 1'b0;
    cyc(2);
    check("t6_rst_valid", 64'(bus.o_valid),  64'd0);
    check("t6_rst_busy",  64'(busy),         64'd0);
    check("t6_rst_state", 64'(dut.state_q),  64'(IDLE));
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    expect_beat(32'hF0, 1'b0);
    expect_beat(32'hF1, 1'b0);
    expect_beat(32'hF2, 1'b0);
    expect_beat(32'hF3, 1'b1);
    load(32'hF0); load(32'hF1); load(32'hF2); load(32'hF3);
    wait_drain("t6_drain", 20);
    cyc(3);
    check("t6_end_busy",  64'(busy),        64'd0);
    check("t6_end_state", 64'(dut.state_q), 64'(RUN));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
